// File: rtl/gray_to_bin_tracker.sv
// gray_to_bin_tracker: receive-side checker for a Gray-coded counter/pointer.
// Stage 1 captures the Gray sample, stage 2 decodes it to binary and
// classifies it against the previous valid sample (hold / +1 / -1 / jump).
// A saturating counter tallies illegal jumps.
module gray_to_bin_tracker #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  gray_in,
  input  logic          in_valid,
  input  logic          clr_err,
  output logic [N-1:0]  bin_out,
  output logic          out_valid,
  output logic          first,
  output logic          step_up,
  output logic          step_down,
  output logic          hold,
  output logic          err,
  output logic [CW-1:0] err_count
);

  localparam logic [N-1:0]  ZERO_N  = {N{1'b0}};
  localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ALL1_N  = {N{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  // Reflected-binary to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [N-1:0] gray_decode(input logic [N-1:0] g);
    logic [N-1:0] b;
    b        = ZERO_N;
    b[N-1]   = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage 1 registers
  logic [N-1:0]  g_q, g_d;
  logic          v1_q, v1_d;
  // Stage 2 registers
  logic [N-1:0]  bin_q, bin_d;
  logic [N-1:0]  prev_q, prev_d;
  logic          has_prev_q, has_prev_d;
  logic          out_valid_q, out_valid_d;
  logic          first_q, first_d;
  logic          step_up_q, step_up_d;
  logic          step_down_q, step_down_d;
  logic          hold_q, hold_d;
  logic          err_q, err_d;
  logic [CW-1:0] err_count_q, err_count_d;
  // Combinational helpers
  logic [N-1:0]  dec_s;
  logic [N-1:0]  diff_s;
  logic [CW-1:0] cnt_base_s;

  // Stage 1: capture the Gray sample on valid, otherwise hold it and drop the strobe.
  always_comb begin
    g_d  = g_q;
    v1_d = 1'b0;
    if (in_valid) begin
      g_d  = gray_in;
      v1_d = 1'b1;
    end else begin
      g_d  = g_q;
      v1_d = 1'b0;
    end
  end

  // Stage 2: decode, classify against the previous sample, and update history.
  always_comb begin
    dec_s       = gray_decode(g_q);
    diff_s      = dec_s - prev_q;
    bin_d       = bin_q;
    prev_d      = prev_q;
    has_prev_d  = has_prev_q;
    out_valid_d = 1'b0;
    first_d     = 1'b0;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    hold_d      = 1'b0;
    err_d       = 1'b0;
    if (v1_q) begin
      bin_d       = dec_s;
      prev_d      = dec_s;
      has_prev_d  = 1'b1;
      out_valid_d = 1'b1;
      if (!has_prev_q) begin
        first_d = 1'b1;
      end else begin
        // Modular difference makes wrap-around a legal single step.
        case (diff_s)
          ZERO_N:  hold_d      = 1'b1;
          ONE_N:   step_up_d   = 1'b1;
          ALL1_N:  step_down_d = 1'b1;
          default: err_d       = 1'b1;
        endcase
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Error counter: apply clear first, then count the error registered this edge, saturating.
  always_comb begin
    cnt_base_s  = err_count_q;
    err_count_d = err_count_q;
    if (clr_err) begin
      cnt_base_s = CNT_ZERO;
    end else begin
      cnt_base_s = err_count_q;
    end
    if (err_d && (cnt_base_s != CNT_MAX)) begin
      err_count_d = cnt_base_s + CNT_ONE;
    end else begin
      err_count_d = cnt_base_s;
    end
  end

  // State registers with synchronous reset; reset flushes any in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q         <= ZERO_N;
      v1_q        <= 1'b0;
      bin_q       <= ZERO_N;
      prev_q      <= ZERO_N;
      has_prev_q  <= 1'b0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= CNT_ZERO;
    end else begin
      g_q         <= g_d;
      v1_q        <= v1_d;
      bin_q       <= bin_d;
      prev_q      <= prev_d;
      has_prev_q  <= has_prev_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign first     = first_q;
  assign step_up   = step_up_q;
  assign step_down = step_down_q;
  assign hold      = hold_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// Testbench for gray_to_bin_tracker: table-driven vectors and hand sequences,
// expectations queued when driven and compared when out_valid appears.
module tb_gray_to_bin_tracker;

  logic       clk;
  logic       rst;
  logic [7:0] gray_in;
  logic       in_valid;
  logic       clr_err;

  logic [7:0] bin_out;
  logic       out_valid, first, step_up, step_down, hold, err;
  logic [7:0] err_count;

  logic [7:0] bin_out2;
  logic       out_valid2, first2, step_up2, step_down2, hold2, err2;
  logic [1:0] err_count2;

  localparam logic [4:0] F_FIRST = 5'b10000;
  localparam logic [4:0] F_UP    = 5'b01000;
  localparam logic [4:0] F_DOWN  = 5'b00100;
  localparam logic [4:0] F_HOLD  = 5'b00010;
  localparam logic [4:0] F_ERR   = 5'b00001;

  gray_to_bin_tracker #(.N(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .clr_err(clr_err),
    .bin_out(bin_out), .out_valid(out_valid), .first(first), .step_up(step_up),
    .step_down(step_down), .hold(hold), .err(err), .err_count(err_count)
  );

  gray_to_bin_tracker #(.N(8), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .clr_err(clr_err),
    .bin_out(bin_out2), .out_valid(out_valid2), .first(first2), .step_up(step_up2),
    .step_down(step_down2), .hold(hold2), .err(err2), .err_count(err_count2)
  );

  typedef struct {
    logic [7:0] bin;
    logic [4:0] flags;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       rst_before;
    int         gap;
    logic [7:0] gray;
    logic [7:0] bin;
    logic [4:0] flags;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   exp_cnt;
  int   exp_cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic vec_t mk(input logic r, input int gap, input logic [7:0] g,
                              input logic [7:0] b, input logic [4:0] f);
    vec_t v;
    v.rst_before = r;
    v.gap        = gap;
    v.gray       = g;
    v.bin        = b;
    v.flags      = f;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge; queue the expected output for valid samples.
  task automatic tick(input logic r, input logic v, input logic [7:0] g, input logic c,
                      input logic [7:0] eb, input logic [4:0] ef);
    exp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    gray_in  = g;
    clr_err  = c;
    if (!r && v) begin
      e.bin   = eb;
      e.flags = ef;
      e.cyc   = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'b00000);
  endtask

  task automatic do_rst();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'b00000);
  endtask

  // Monitor: sample just after each rising edge, compare against the scoreboard and counter model.
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      sb.delete();
      exp_cnt  = 0;
      exp_cnt2 = 0;
      chk("reset_outputs", {23'd0, bin_out, out_valid, first, step_up, step_down, hold, err}, 32'd0);
      chk("reset_err_count", {24'd0, err_count}, 32'd0);
    end else begin
      if (clr_err) begin
        exp_cnt  = 0;
        exp_cnt2 = 0;
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("bin_out", {24'd0, bin_out}, {24'd0, e.bin});
        chk("flags", {27'd0, first, step_up, step_down, hold, err}, {27'd0, e.flags});
        chk("cw2_flags", {27'd0, first2, step_up2, step_down2, hold2, err2}, {27'd0, e.flags});
        if (e.flags[0]) begin
          if (exp_cnt < 255) exp_cnt++;
          if (exp_cnt2 < 3) exp_cnt2++;
        end
      end else begin
        chk("no_out_valid", {31'd0, out_valid}, 32'd0);
      end
      chk("err_count", {24'd0, err_count}, exp_cnt);
      chk("err_count_cw2", {30'd0, err_count2}, exp_cnt2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc      = 0;
    n_tests  = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = 8'h00;
    clr_err  = 1'b0;

    // First sample after reset
    tbl.push_back(mk(1'b1, 0, 8'h00, 8'd0, F_FIRST));
    // 5, 6, 5, 5 -> first, up, down, hold
    tbl.push_back(mk(1'b1, 0, 8'h07, 8'd5, F_FIRST));
    tbl.push_back(mk(1'b0, 0, 8'h05, 8'd6, F_UP));
    tbl.push_back(mk(1'b0, 0, 8'h07, 8'd5, F_DOWN));
    tbl.push_back(mk(1'b0, 0, 8'h07, 8'd5, F_HOLD));
    // 5 -> 3 jump after a gap, then hold
    tbl.push_back(mk(1'b1, 0, 8'h07, 8'd5, F_FIRST));
    tbl.push_back(mk(1'b0, 3, 8'h02, 8'd3, F_ERR));
    tbl.push_back(mk(1'b0, 0, 8'h02, 8'd3, F_HOLD));
    // Wrap downward and back upward
    tbl.push_back(mk(1'b1, 0, 8'h00, 8'd0, F_FIRST));
    tbl.push_back(mk(1'b0, 0, 8'h80, 8'd255, F_DOWN));
    tbl.push_back(mk(1'b0, 2, 8'h00, 8'd0, F_UP));
    // Single Gray bit change that is not a unit step
    tbl.push_back(mk(1'b1, 0, 8'h01, 8'd1, F_FIRST));
    tbl.push_back(mk(1'b0, 0, 8'h05, 8'd6, F_ERR));

    repeat (3) do_rst();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_rst();
      for (int k = 0; k < tbl[i].gap; k++) idle();
      tick(1'b0, 1'b1, tbl[i].gray, 1'b0, tbl[i].bin, tbl[i].flags);
    end
    repeat (3) idle();

    // Full sweep 0..255 then back to 0, back-to-back
    do_rst();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      tick(1'b0, 1'b1, b ^ (b >> 1), 1'b0, b, (i == 0) ? F_FIRST : F_UP);
    end
    tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_UP);
    repeat (3) idle();
    chk("sweep_err_count", {24'd0, err_count}, 32'd0);

    // Saturation: five jumps between 0 and 128
    do_rst();
    tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_FIRST);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) tick(1'b0, 1'b1, 8'hC0, 1'b0, 8'd128, F_ERR);
      else            tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_ERR);
    end
    repeat (3) idle();
    chk("sat_count_cw8", {24'd0, err_count}, 32'd5);
    chk("sat_count_cw2", {30'd0, err_count2}, 32'd3);

    // Clear coinciding with an error yields 1; clear alone yields 0
    do_rst();
    tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_FIRST);
    tick(1'b0, 1'b1, 8'hC0, 1'b0, 8'd128, F_ERR);
    tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_ERR);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 5'b00000);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 5'b00000);
    chk("clr_with_err", {24'd0, err_count}, 32'd1);
    idle();
    chk("clr_alone", {24'd0, err_count}, 32'd0);

    // Reset mid-stream with samples in both stages
    do_rst();
    tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_FIRST);
    tick(1'b0, 1'b1, 8'hC0, 1'b0, 8'd128, F_ERR);
    tick(1'b0, 1'b1, 8'h00, 1'b0, 8'd0, F_ERR);
    tick(1'b0, 1'b1, 8'h07, 1'b0, 8'd5, F_ERR);
    tick(1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 5'b00000);
    idle();
    chk("flush_err_count", {24'd0, err_count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    idle();
    chk("flush_no_late_out", {31'd0, out_valid}, 32'd0);
    tick(1'b0, 1'b1, 8'h05, 1'b0, 8'd6, F_FIRST);
    repeat (4) idle();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
